// File: rtl/lsm_sequencer_p.sv
`default_nettype none
// ============================================================================
//  Module      : lsm_sequencer_p
//  Description : Parametrised load/store-multiple sequencer. Walks a latched
//                register mask lowest-index first, generating the word
//                address and register index for each transfer under the
//                IA/IB/DA/DB addressing modes. Uses a MOC memory handshake,
//                computes the base writeback value, and suppresses
//                writeback when a load also writes the base register.
//  Revision    : 1.0 - initial release
// ============================================================================
module lsm_sequencer_p #(
   parameter int NREGS  = 16,
   parameter int IDX_W  = 4,
   parameter int ADDR_W = 32
) (
   input  logic              CLK,
   input  logic              RESET,
   input  logic              START,
   input  logic [NREGS-1:0]  REG_LIST,
   input  logic [ADDR_W-1:0] BASE,
   input  logic [IDX_W-1:0]  BASE_IDX,
   input  logic              P_BIT,
   input  logic              U_BIT,
   input  logic              L_BIT,
   input  logic              W_BIT,
   input  logic              MOC,
   output logic              BUSY,
   output logic              MEM_REQ,
   output logic              MEM_RW,
   output logic [ADDR_W-1:0] MEM_ADDR,
   output logic [IDX_W-1:0]  REG_IDX,
   output logic              RF_WE,
   output logic              WB_EN,
   output logic [ADDR_W-1:0] WB_VALUE,
   output logic              DONE
);

   // Popcount needs one bit more than the index to hold NREGS itself.
   localparam int                c_CNT_W = IDX_W + 1;
   localparam logic [ADDR_W-1:0] c_WORD  = ADDR_W'(4);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_SETUP  = 3'd1,
      S_ACCESS = 3'd2,
      S_WB     = 3'd3,
      S_DONE   = 3'd4
   } state_t;

   state_t              r_state;
   state_t              w_state_next;

   // Latched operation context.
   logic [NREGS-1:0]    r_list;       // original list, kept for the base-in-list rule
   logic [NREGS-1:0]    r_mask;       // remaining registers still to transfer
   logic [ADDR_W-1:0]   r_base;
   logic [IDX_W-1:0]    r_base_idx;
   logic                r_p;
   logic                r_u;
   logic                r_l;
   logic                r_w;

   // Address generation state.
   logic [ADDR_W-1:0]   r_addr;       // address of the transfer in progress
   logic [ADDR_W-1:0]   r_addr_hold;  // last presented address, shown outside ACCESS
   logic [IDX_W-1:0]    r_idx_hold;   // last presented index, shown outside ACCESS
   logic [ADDR_W-1:0]   r_wb_value;

   // Combinational helpers.
   logic [c_CNT_W-1:0]  w_count;
   logic [ADDR_W-1:0]   w_span;       // 4 * number of registers in the list
   logic [ADDR_W-1:0]   w_start_addr;
   logic [IDX_W-1:0]    w_low_idx;
   logic [NREGS-1:0]    w_mask_next;
   logic                w_base_loaded;

   // Count the registers in the latched mask (only meaningful in SETUP).
   always_comb begin
      w_count = '0;
      for (int i = 0; i < NREGS; i++) begin
         w_count = w_count + c_CNT_W'(r_mask[i]);
      end
      w_span = ADDR_W'(w_count) << 2;
   end

   // Lowest set bit of the remaining mask selects the next register.
   always_comb begin
      w_low_idx = '0;
      for (int i = NREGS - 1; i >= 0; i--) begin
         if (r_mask[i]) begin
            w_low_idx = IDX_W'(i);
         end
      end
      // Clearing the lowest set bit retires the current register.
      w_mask_next   = r_mask & (r_mask - NREGS'(1));
      w_base_loaded = r_l & r_list[r_base_idx];
   end

   // Lowest address of the block; all modes then walk upwards in 4-byte steps.
   always_comb begin
      w_start_addr = r_base;
      case ({r_p, r_u})
         2'b01:   w_start_addr = r_base;                   // IA
         2'b11:   w_start_addr = r_base + c_WORD;          // IB
         2'b00:   w_start_addr = r_base - w_span + c_WORD; // DA
         default: w_start_addr = r_base - w_span;          // DB
      endcase
   end

   // State register.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Datapath registers: operand latch, address walk, writeback value.
   always_ff @(posedge CLK) begin
      if (RESET) begin
         r_list      <= '0;
         r_mask      <= '0;
         r_base      <= '0;
         r_base_idx  <= '0;
         r_p         <= 1'b0;
         r_u         <= 1'b0;
         r_l         <= 1'b0;
         r_w         <= 1'b0;
         r_addr      <= '0;
         r_addr_hold <= '0;
         r_idx_hold  <= '0;
         r_wb_value  <= '0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (START) begin
                  r_list     <= REG_LIST;
                  r_mask     <= REG_LIST;
                  r_base     <= BASE;
                  r_base_idx <= BASE_IDX;
                  r_p        <= P_BIT;
                  r_u        <= U_BIT;
                  r_l        <= L_BIT;
                  r_w        <= W_BIT;
               end
            end
            S_SETUP: begin
               r_addr     <= w_start_addr;
               // An empty list gives a zero span, so this reduces to BASE.
               r_wb_value <= r_u ? (r_base + w_span) : (r_base - w_span);
            end
            S_ACCESS: begin
               r_addr_hold <= r_addr;
               r_idx_hold  <= w_low_idx;
               if (MOC) begin
                  r_mask <= w_mask_next;
                  r_addr <= r_addr + c_WORD;
               end
            end
            default: begin
            end
         endcase
      end
   end

   // Next-state decode and per-state output strobes.
   always_comb begin
      w_state_next = r_state;
      BUSY         = (r_state != S_IDLE);
      MEM_REQ      = 1'b0;
      MEM_RW       = 1'b0;
      MEM_ADDR     = r_addr_hold;
      REG_IDX      = r_idx_hold;
      RF_WE        = 1'b0;
      WB_EN        = 1'b0;
      DONE         = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (START) begin
               w_state_next = S_SETUP;
            end
         end
         S_SETUP: begin
            w_state_next = (w_count == '0) ? S_DONE : S_ACCESS;
         end
         S_ACCESS: begin
            MEM_REQ  = 1'b1;
            MEM_RW   = r_l;
            MEM_ADDR = r_addr;
            REG_IDX  = w_low_idx;
            if (MOC) begin
               RF_WE = r_l;
               if (w_mask_next == '0) begin
                  w_state_next = S_WB;
               end
            end
         end
         S_WB: begin
            // A base register reloaded from memory takes precedence.
            WB_EN        = r_w & ~w_base_loaded;
            w_state_next = S_DONE;
         end
         S_DONE: begin
            DONE         = 1'b1;
            w_state_next = S_IDLE;
         end
         default: begin
            w_state_next = S_IDLE;
         end
      endcase
   end

   assign WB_VALUE = r_wb_value;

endmodule
`default_nettype wire

// File: tb/tb_lsm_sequencer_p.sv
`default_nettype none
// ============================================================================
//  Module      : tb_lsm_sequencer_p
//  Description : Directed self-checking bench for lsm_sequencer_p. Expected
//                transfers are queued when an operation is issued and popped
//                as the sequencer presents them.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_lsm_sequencer_p;

   logic        CLK;
   logic        RESET;
   logic        START;
   logic [15:0] REG_LIST;
   logic [31:0] BASE;
   logic [3:0]  BASE_IDX;
   logic        P_BIT;
   logic        U_BIT;
   logic        L_BIT;
   logic        W_BIT;
   logic        MOC;
   logic        BUSY;
   logic        MEM_REQ;
   logic        MEM_RW;
   logic [31:0] MEM_ADDR;
   logic [3:0]  REG_IDX;
   logic        RF_WE;
   logic        WB_EN;
   logic [31:0] WB_VALUE;
   logic        DONE;

   typedef struct packed {
      logic [31:0] addr;
      logic [3:0]  idx;
   } xfer_t;

   xfer_t q[$];
   int    checks = 0;
   int    errors = 0;

   lsm_sequencer_p #(.NREGS(16), .IDX_W(4), .ADDR_W(32)) dut (
      .CLK(CLK), .RESET(RESET), .START(START), .REG_LIST(REG_LIST),
      .BASE(BASE), .BASE_IDX(BASE_IDX), .P_BIT(P_BIT), .U_BIT(U_BIT),
      .L_BIT(L_BIT), .W_BIT(W_BIT), .MOC(MOC), .BUSY(BUSY),
      .MEM_REQ(MEM_REQ), .MEM_RW(MEM_RW), .MEM_ADDR(MEM_ADDR),
      .REG_IDX(REG_IDX), .RF_WE(RF_WE), .WB_EN(WB_EN),
      .WB_VALUE(WB_VALUE), .DONE(DONE)
   );

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_busy"},  32'(BUSY),    32'd0);
      check({tag, "_req"},   32'(MEM_REQ), 32'd0);
      check({tag, "_rw"},    32'(MEM_RW),  32'd0);
      check({tag, "_addr"},  MEM_ADDR,     32'd0);
      check({tag, "_idx"},   32'(REG_IDX), 32'd0);
      check({tag, "_rfwe"},  32'(RF_WE),   32'd0);
      check({tag, "_wben"},  32'(WB_EN),   32'd0);
      check({tag, "_wbval"}, WB_VALUE,     32'd0);
      check({tag, "_done"},  32'(DONE),    32'd0);
   endtask

   // Issue one block transfer and follow it to DONE, checking every cycle.
   task automatic run_op(input string tag, input logic [31:0] base, input logic [15:0] list,
                         input logic [3:0] bidx, input logic p, input logic u,
                         input logic l, input logic w, input int waits,
                         input logic busy_pulse, input logic exp_wb_en,
                         input logic [31:0] exp_wbv);
      int          n;
      int          k;
      int          cyc;
      int          waited;
      int          wb_cnt;
      int          lat;
      bit          done_seen;
      logic [31:0] a;
      logic [31:0] last_addr;
      logic [3:0]  last_idx;
      xfer_t       e;

      // Reference model: lowest block address, ascending registers.
      n = 0;
      for (int i = 0; i < 16; i++) n += int'(list[i]);
      if (u) a = p ? base + 32'd4 : base;
      else   a = p ? base - 32'(4 * n) : base - 32'(4 * n) + 32'd4;
      k = 0;
      last_addr = '0;
      last_idx  = '0;
      for (int i = 0; i < 16; i++) begin
         if (list[i]) begin
            last_addr = a + 32'(4 * k);
            last_idx  = 4'(i);
            q.push_back('{addr: last_addr, idx: last_idx});
            k++;
         end
      end

      @(negedge CLK);
      BASE = base; REG_LIST = list; BASE_IDX = bidx;
      P_BIT = p; U_BIT = u; L_BIT = l; W_BIT = w;
      START = 1'b1; MOC = 1'b0;
      #1 check({tag, "_idle_busy"}, 32'(BUSY), 32'd0);

      @(negedge CLK);
      // Scramble inputs: the operation must run from the latched copies.
      BASE = ~base; REG_LIST = ~list; BASE_IDX = ~bidx;
      P_BIT = ~p; U_BIT = ~u; L_BIT = ~l; W_BIT = ~w;
      cyc = 1; waited = 0; wb_cnt = 0; lat = 0; done_seen = 0;
      while (!done_seen && cyc <= 100) begin
         MOC   = 1'b0;
         START = busy_pulse;
         #1;
         if (MEM_REQ) begin
            if (q.size() == 0) begin
               check({tag, "_spurious_req"}, 32'(MEM_REQ), 32'd0);
            end else begin
               e = q[0];
               check({tag, "_addr"}, MEM_ADDR, e.addr);
               check({tag, "_idx"}, 32'(REG_IDX), 32'(e.idx));
               check({tag, "_rw"}, 32'(MEM_RW), 32'(l));
               MOC = (waited >= waits);
               #1;
               check({tag, "_rfwe"}, 32'(RF_WE), 32'(MOC & l));
               if (MOC) begin
                  void'(q.pop_front());
                  waited = 0;
               end else begin
                  waited++;
               end
            end
         end else begin
            #1 check({tag, "_rfwe_idle"}, 32'(RF_WE), 32'd0);
         end
         if (WB_EN) wb_cnt++;
         if (DONE) begin
            done_seen = 1;
            lat = cyc;
         end else begin
            @(negedge CLK);
            cyc++;
         end
      end

      check({tag, "_done_seen"}, 32'(done_seen), 32'd1);
      check({tag, "_latency"}, 32'(lat), (n == 0) ? 32'd2 : 32'(n + 3 + n * waits));
      check({tag, "_queue_empty"}, 32'(q.size()), 32'd0);
      check({tag, "_wb_en"}, 32'(wb_cnt), 32'(exp_wb_en));
      check({tag, "_wb_value"}, WB_VALUE, exp_wbv);
      if (n > 0) begin
         check({tag, "_addr_hold"}, MEM_ADDR, last_addr);
         check({tag, "_idx_hold"}, 32'(REG_IDX), 32'(last_idx));
      end
      q.delete();

      @(negedge CLK);
      START = 1'b0; MOC = 1'b0;
      #1;
      check({tag, "_idle_after"}, 32'(BUSY), 32'd0);
      check({tag, "_done_low"}, 32'(DONE), 32'd0);
   endtask

   // Directed sequence covering modes, wait states, wrap, base-in-list and reset.
   initial begin
      RESET = 1'b1; START = 1'b0; REG_LIST = '0; BASE = '0; BASE_IDX = '0;
      P_BIT = 1'b0; U_BIT = 1'b0; L_BIT = 1'b0; W_BIT = 1'b0; MOC = 1'b0;
      repeat (3) @(negedge CLK);
      #1 check_all_zero("reset");
      RESET = 1'b0;

      // IA load, zero wait, registers 0/1/3.
      run_op("ia_load", 32'h100, 16'h000B, 4'd13, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b1, 32'h10C);
      // DB store with two wait cycles per access and START pulsed while busy.
      run_op("db_store", 32'h200, 16'h8030, 4'd0, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1'b1, 1'b1, 32'h1F4);
      // DA single register at base 0, no writeback requested.
      run_op("da_one", 32'h0, 16'h0001, 4'd7, 1'b0, 1'b0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 32'hFFFF_FFFC);
      // IB single register at base 0.
      run_op("ib_one", 32'h0, 16'h0001, 4'd7, 1'b1, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h4);
      // DA two registers wrapping through zero.
      run_op("da_wrap", 32'h0, 16'h0003, 4'd5, 1'b0, 1'b0, 1'b1, 1'b1, 0, 1'b0, 1'b1, 32'hFFFF_FFF8);
      // Base in list: a load suppresses writeback, a store keeps it.
      run_op("base_ld", 32'h40, 16'h0004, 4'd2, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b0, 1'b0, 32'h44);
      run_op("base_st", 32'h40, 16'h0004, 4'd2, 1'b0, 1'b1, 1'b0, 1'b1, 0, 1'b0, 1'b1, 32'h44);
      // Empty list with START held high while busy.
      run_op("empty", 32'h1234, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b1, 1'b1, 0, 1'b1, 1'b0, 32'h1234);

      // Reset during the second of four transfers.
      @(negedge CLK);
      BASE = 32'h300; REG_LIST = 16'h00F0; BASE_IDX = 4'd0;
      P_BIT = 1'b0; U_BIT = 1'b1; L_BIT = 1'b1; W_BIT = 1'b1; START = 1'b1;
      @(negedge CLK);
      START = 1'b0;
      @(negedge CLK);
      #1;
      check("rst_x1_req", 32'(MEM_REQ), 32'd1);
      check("rst_x1_addr", MEM_ADDR, 32'h300);
      check("rst_x1_idx", 32'(REG_IDX), 32'd4);
      MOC = 1'b1;
      #1 check("rst_x1_rfwe", 32'(RF_WE), 32'd1);
      @(negedge CLK);
      MOC = 1'b0;
      #1;
      check("rst_x2_req", 32'(MEM_REQ), 32'd1);
      check("rst_x2_addr", MEM_ADDR, 32'h304);
      check("rst_x2_idx", 32'(REG_IDX), 32'd5);
      RESET = 1'b1;
      @(negedge CLK);
      RESET = 1'b0;
      #1 check_all_zero("rst_mid");

      // Normal operation after the abort, with a wrapping IA load and waits.
      run_op("post_rst", 32'hFFFF_FFF8, 16'h0C00, 4'd10, 1'b0, 1'b1, 1'b1, 1'b1, 1, 1'b0, 1'b0, 32'h0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lsm_sequencer_p.md
Name: lsm_sequencer_p

Overview:
- Parametrised load/store-multiple sequencer.
- Handles all four ARM block-transfer addressing modes (IA, IB, DA, DB) and base writeback, with a MOC-based memory handshake.
- Sits between the control unit and the register file / MAR / RAM. It steps through the register list one word at a time, supplies the register index and word address for each transfer, and reports completion.
- Replaces the fixed-width LSM counter with a generic register count and adds address generation, writeback and a base-in-list rule.

Parameters:
NREGS, 16, number of architectural registers (bits in REG_LIST); must be a power of two, 2 to 32.
IDX_W, 4, register index width; must equal log2(NREGS).
ADDR_W, 32, address width; all address arithmetic is modulo 2^ADDR_W.

Ports:
CLK  input  1  clock, rising edge.
RESET  input  1  synchronous, active-high reset.
START  input  1  begin operation; sampled only in IDLE.
REG_LIST  input  NREGS  register mask (IR[15:0] for NREGS=16).
BASE  input  ADDR_W  base register value (Rn contents).
BASE_IDX  input  IDX_W  base register number (Rn).
P_BIT  input  1  pre(1)/post(0) indexing.
U_BIT  input  1  up(1)/down(0).
L_BIT  input  1  load(1)/store(0).
W_BIT  input  1  writeback request.
MOC  input  1  memory operation complete.
BUSY  output  1  high in every state except IDLE.
MEM_REQ  output  1  memory access request.
MEM_RW  output  1  1 = read, 0 = write; equals the latched L_BIT during ACCESS.
MEM_ADDR  output  ADDR_W  word address of the current transfer.
REG_IDX  output  IDX_W  register for the current transfer.
RF_WE  output  1  register-file write strobe for load data.
WB_EN  output  1  base writeback strobe.
WB_VALUE  output  ADDR_W  writeback value for Rn.
DONE  output  1  one-cycle completion pulse.

Behaviour:
- Reset: state IDLE; all outputs 0; internal mask, address, count and latched bits cleared. Reset has priority in every state and aborts an operation mid-transfer with no further strobes.
- IDLE:
  - START=1 latches REG_LIST, BASE, BASE_IDX, P, U, L and W, then moves to SETUP.
  - START while not in IDLE is ignored.
- SETUP (1 cycle):
  - N = popcount(mask).
  - Start address by mode:
    - IA (P=0,U=1): BASE
    - IB (P=1,U=1): BASE+4
    - DA (P=0,U=0): BASE-4N+4
    - DB (P=1,U=0): BASE-4N
  - WB_VALUE register loads BASE+4N if U=1, otherwise BASE-4N. It holds until the next SETUP.
  - If N=0, go to DONE: no memory access, WB_EN stays 0, WB_VALUE=BASE.
  - Otherwise go to ACCESS.
- ACCESS:
  - MEM_REQ=1, MEM_RW=L, MEM_ADDR=current address.
  - REG_IDX = index of the lowest set bit of the remaining mask (registers are always transferred in ascending order at ascending addresses).
  - While MOC=0, hold all outputs stable; there is no timeout.
  - On a cycle with MOC=1:
    - RF_WE=L, combinationally in that same cycle.
    - That mask bit is cleared and the address advances by 4 at the clock edge.
    - If the remaining mask is now empty, go to WB; otherwise stay in ACCESS and present the next register the following cycle.
  - MEM_REQ may stay high back-to-back across transfers.
- WB (1 cycle): WB_EN = W AND NOT (L AND mask bit BASE_IDX of the latched list). A loaded base value wins over writeback. Go to DONE.
- DONE (1 cycle): DONE=1, BUSY=1; go to IDLE. START is accepted again from the next cycle.
- Outside ACCESS: MEM_REQ=0, RF_WE=0, MEM_ADDR and REG_IDX hold their last values.
- Latency for N registers with zero-wait memory (MOC high on the first ACCESS cycle): START edge to DONE pulse = N+3 cycles (SETUP, N×ACCESS, WB, DONE).
- Address wrap: 0xFFFFFFFC+4 = 0x00000000 with no flag.
- Store with the base in the list stores the original BASE value; the register file supplies it, and no special action is needed here.

Test Plan:
- IA load, zero-wait: BASE=0x100, REG_LIST=0x000B, L=1, W=1 → MEM_ADDR 0x100/0x104/0x108 with REG_IDX 0/1/3, RF_WE high on each; WB_EN=1, WB_VALUE=0x10C; DONE at cycle 6 after START.
- DB store with wait states: BASE=0x200, REG_LIST=0x8030, U=0, P=1, L=0, MOC delayed 2 cycles per access → addresses 0x1F4/0x1F8/0x1FC for REG_IDX 4/5/15; outputs stable while waiting; RF_WE never asserted; WB_VALUE=0x1F4.
- IB/DA boundaries: BASE=0x0, REG_LIST=0x0001, DA → address 0x0; IB → address 0x4; DA with REG_LIST=0x0003 → 0xFFFFFFFC then 0x0 (wrap).
- Base in list: load, BASE_IDX=2, REG_LIST=0x0004, W=1 → WB_EN=0. Same case as a store → WB_EN=1, WB_VALUE=BASE+4.
- Empty list: REG_LIST=0 → no MEM_REQ, WB_EN=0, DONE 2 cycles after START. START pulsed while BUSY → ignored.
- Reset mid-ACCESS on the second of 4 transfers → next cycle BUSY=0 and all outputs 0; a new START then runs normally from SETUP.
